fft_butterfly_pipe: RTL and testbench

Parametrised, pipelined radix-2 decimation-in-time butterfly for the FFT datapath. It computes `out1 = a + W·b` and `out2 = a − W·b` on signed fixed-point complex samples with a Q1.(TW−1) twiddle. It has a valid/ready stream handshake and an optional per-sample divide-by-2 for block scaling. It sits between the stage sample/twiddle fetch logic and the stage write-back, one instance per FFT stage lane.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_cmul_pipe.sv | 77 +++++++
 rtl/fft_butterfly_pipe.sv | 108 ++++++++++
 tb/tb_fft_butterfly_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared widths, twiddle constants and the twiddle fraction-bit
//               derivation for the FFT butterfly datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_DW = 16;
    localparam int FFT_TW = 16;

    // Twiddles are Q1.(TW-1): one sign bit, the rest fractional.
    function automatic int frac_bits(input int tw);
        return tw - 1;
    endfunction

    localparam int FFT_FRAC = frac_bits(FFT_TW);

    localparam logic signed [FFT_TW-1:0] TW_ONE_M   = 16'sd32767;
    localparam logic signed [FFT_TW-1:0] TW_NEG_ONE = -16'sd32768;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_cmul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft_cmul_pipe
// Description : Two-stage pipelined complex multiply b*W with the Q1.(TW-1)
//               fraction shift applied combinationally on the product stage.
//               FFT_BFLY_ROUND_EN selects round-half-up instead of floor.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_cmul_pipe
    import fft_pkg::*;
#(
    parameter  int DW = FFT_DW,
    parameter  int TW = FFT_TW,
    localparam int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [OW-1:0] t_re,
    output logic signed [OW-1:0] t_im
);

    localparam int FRAC = frac_bits(TW);
    localparam int PW   = DW + TW;
    localparam int SW   = PW + 1;

    logic signed [DW-1:0] r_b_re, r_b_im;
    logic signed [TW-1:0] r_w_re, r_w_im;
    logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [SW-1:0] w_p_re, w_p_im;
    logic signed [SW-1:0] w_q_re, w_q_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_re <= '0;
            r_b_im <= '0;
            r_w_re <= '0;
            r_w_im <= '0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
        end else if (en) begin
            r_b_re <= b_re;
            r_b_im <= b_im;
            r_w_re <= w_re;
            r_w_im <= w_im;
            r_p_rr <= PW'(r_b_re) * PW'(r_w_re);
            r_p_ii <= PW'(r_b_im) * PW'(r_w_im);
            r_p_ri <= PW'(r_b_re) * PW'(r_w_im);
            r_p_ir <= PW'(r_b_im) * PW'(r_w_re);
        end
    end

    // One extra bit absorbs the sum/difference of two full-width products.
    assign w_p_re = SW'(r_p_rr) - SW'(r_p_ii);
    assign w_p_im = SW'(r_p_ri) + SW'(r_p_ir);

`ifdef FFT_BFLY_ROUND_EN
    localparam logic signed [SW-1:0] c_half = SW'(1) << (FRAC - 1);
    assign w_q_re = w_p_re + c_half;
    assign w_q_im = w_p_im + c_half;
`else
    assign w_q_re = w_p_re;
    assign w_q_im = w_p_im;
`endif

    // SW - FRAC == OW, so the shifted value fits the output exactly.
    assign t_re = OW'(w_q_re >>> FRAC);
    assign t_im = OW'(w_q_im >>> FRAC);

endmodule : fft_cmul_pipe
`default_nettype wire

// File: rtl/fft_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft_butterfly_pipe
// Description : Three-stage radix-2 DIT butterfly out1 = a + W*b,
//               out2 = a - W*b with valid/ready handshake and optional /2.
//               FFT_BFLY_ROUND_EN selects round-half-up at both shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_butterfly_pipe
    import fft_pkg::*;
#(
    parameter  int DW = FFT_DW,
    parameter  int TW = FFT_TW,
    localparam int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out1_re,
    output logic signed [OW-1:0] out1_im,
    output logic signed [OW-1:0] out2_re,
    output logic signed [OW-1:0] out2_im
);

    function automatic logic signed [OW-1:0] halve(input logic signed [OW-1:0] x,
                                                   input logic                 sc);
`ifdef FFT_BFLY_ROUND_EN
        return sc ? ((x + OW'(1)) >>> 1) : x;
`else
        return sc ? (x >>> 1) : x;
`endif
    endfunction

    logic                 w_en;
    logic                 r_v1, r_v2;
    logic                 r_sc1, r_sc2;
    logic signed [DW-1:0] r_a1_re, r_a1_im, r_a2_re, r_a2_im;
    logic signed [OW-1:0] w_t_re, w_t_im;
    logic signed [OW-1:0] w_s1_re, w_s1_im, w_s2_re, w_s2_im;

    // Whole pipeline moves together; a full, stalled output freezes every stage.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    fft_cmul_pipe #(
        .DW (DW),
        .TW (TW)
    ) u_cmul (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .b_re (b_re),
        .b_im (b_im),
        .w_re (w_re),
        .w_im (w_im),
        .t_re (w_t_re),
        .t_im (w_t_im)
    );

    assign w_s1_re = OW'(r_a2_re) + w_t_re;
    assign w_s1_im = OW'(r_a2_im) + w_t_im;
    assign w_s2_re = OW'(r_a2_re) - w_t_re;
    assign w_s2_im = OW'(r_a2_im) - w_t_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            r_sc1     <= 1'b0;
            r_sc2     <= 1'b0;
            r_a1_re   <= '0;
            r_a1_im   <= '0;
            r_a2_re   <= '0;
            r_a2_im   <= '0;
            out1_re   <= '0;
            out1_im   <= '0;
            out2_re   <= '0;
            out2_im   <= '0;
        end else if (w_en) begin
            r_v1      <= in_valid;
            r_sc1     <= scale;
            r_a1_re   <= a_re;
            r_a1_im   <= a_im;
            r_v2      <= r_v1;
            r_sc2     <= r_sc1;
            r_a2_re   <= r_a1_re;
            r_a2_im   <= r_a1_im;
            out_valid <= r_v2;
            out1_re   <= halve(w_s1_re, r_sc2);
            out1_im   <= halve(w_s1_im, r_sc2);
            out2_re   <= halve(w_s2_re, r_sc2);
            out2_im   <= halve(w_s2_im, r_sc2);
        end
    end

endmodule : fft_butterfly_pipe
`default_nettype wire

// File: tb/tb_fft_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_butterfly_pipe
// Description : Scoreboard bench for fft_butterfly_pipe (DW=TW=16); expected
//               values follow FFT_BFLY_ROUND_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_butterfly_pipe;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int TW = 16;
    localparam int OW = DW + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, scale, out_valid, out_ready;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [OW-1:0] out1_re, out1_im, out2_re, out2_im;

    always #5 clk = ~clk;

    fft_butterfly_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1_re   (out1_re),
        .out1_im   (out1_im),
        .out2_re   (out2_re),
        .out2_im   (out2_im)
    );

    typedef struct {
        longint o1r, o1i, o2r, o2i;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input longint r1, i1, r2, i2);
        exp_t e;
        e.o1r = r1; e.o1i = i1; e.o2r = r2; e.o2i = i2;
        return e;
    endfunction

    function automatic longint shr1(input longint x, input bit sc);
`ifdef FFT_BFLY_ROUND_EN
        return sc ? ((x + 1) >>> 1) : x;
`else
        return sc ? (x >>> 1) : x;
`endif
    endfunction

    function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input bit sc);
        longint pre, pim, tre, tim;
        pre = longint'(br) * wr - longint'(bi) * wi;
        pim = longint'(br) * wi + longint'(bi) * wr;
`ifdef FFT_BFLY_ROUND_EN
        pre += 16384;
        pim += 16384;
`endif
        tre = pre >>> 15;
        tim = pim >>> 15;
        return mk(shr1(ar + tre, sc), shr1(ai + tim, sc),
                  shr1(ar - tre, sc), shr1(ai - tim, sc));
    endfunction

    // Output monitor: scoreboard pop on transfer, stability check while stalled.
    exp_t                 mon_e;
    bit                   held = 1'b0;
    logic signed [OW-1:0] h1r, h1i, h2r, h2i;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_o1r", out1_re, h1r);
                chk("hold_o1i", out1_im, h1i);
                chk("hold_o2r", out2_re, h2r);
                chk("hold_o2i", out2_im, h2i);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("o1r", out1_re, mon_e.o1r);
                    chk("o1i", out1_im, mon_e.o1i);
                    chk("o2r", out2_re, mon_e.o2r);
                    chk("o2i", out2_im, mon_e.o2i);
                end
            end
            held = out_valid && !out_ready;
            h1r = out1_re; h1i = out1_im; h2r = out2_re; h2i = out2_im;
        end
    end

    task automatic set_in(input int ar, ai, br, bi, wr, wi, input bit sc);
        a_re = 16'(ar); a_im = 16'(ai);
        b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        scale = sc;
    endtask

    task automatic send(input int ar, ai, br, bi, wr, wi, input bit sc, input exp_t e);
        int wcnt = 0;
        sb.push_back(e);
        set_in(ar, ai, br, bi, wr, wi, sc);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && wcnt < 100) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            wcnt++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_m(input int ar, ai, br, bi, wr, wi, input bit sc);
        send(ar, ai, br, bi, wr, wi, sc, model(ar, ai, br, bi, wr, wi, sc));
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Counts edges from the acceptance edge (inclusive) until out_valid rises.
    task automatic latency(input string tag);
        int lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, lat, 3);
    endtask

    int   acc, n0;
    int   bp[5][7];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_o1r", out1_re, 0);
        chk("reset_o2i", out2_im, 0);
        @(posedge clk); #1;

`ifdef FFT_BFLY_ROUND_EN
        send(1, 0, 1, 0, TW_ONE_M, 0, 1'b0, mk(2, 0, 0, 0));
`else
        send(1, 0, 1, 0, TW_ONE_M, 0, 1'b0, mk(1, 0, 1, 0));
`endif
        send(1000, 0, 2000, 0, TW_NEG_ONE, 0, 1'b0, mk(-1000, 0, 3000, 0));
`ifdef FFT_BFLY_ROUND_EN
        send(3, 0, 0, 0, 0, 0, 1'b1, mk(2, 0, 2, 0));
        send(-3, 0, 0, 0, 0, 0, 1'b1, mk(-1, 0, -1, 0));
`else
        send(3, 0, 0, 0, 0, 0, 1'b1, mk(1, 0, 1, 0));
        send(-3, 0, 0, 0, 0, 0, 1'b1, mk(-2, 0, -2, 0));
`endif
        drain();

        send(1000, 0, 2000, 0, 0, TW_NEG_ONE, 1'b0, mk(1000, -2000, 1000, 2000));
        latency("latency_neg_j");
        drain();

        for (int i = 0; i < 20; i++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
        drain();

        // Backpressure: five offered against a stalled output.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 6; j++) bp[i][j] = rnd16();
            bp[i][6] = int'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        acc = 0;
        n0 = n_out;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (acc < 5) set_in(bp[acc][0], bp[acc][1], bp[acc][2], bp[acc][3], bp[acc][4], bp[acc][5], bp[acc][6][0]);
            in_valid = (acc < 5);
            @(negedge clk);
            if (cyc == 3) chk("bp_in_ready_cycle4", longint'(in_ready), 0);
            if (in_valid && in_ready) begin
                sb.push_back(model(bp[acc][0], bp[acc][1], bp[acc][2], bp[acc][3], bp[acc][4], bp[acc][5], bp[acc][6][0]));
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc, 3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 3; k < 5; k++)
            send_m(bp[k][0], bp[k][1], bp[k][2], bp[k][3], bp[k][4], bp[k][5], bp[k][6][0]);
        drain();
        chk("bp_out_count", n_out - n0, 5);

        // Reset with three samples in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_o1r", out1_re, 0);
        chk("rst_o2r", out2_re, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", n_out - n0, 0);
        send_m(1234, -567, 890, -4321, 20000, -15000, 1'b0);
        latency("latency_after_rst");
        drain();

        // Random traffic with random downstream stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++)
            send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fft_butterfly_pipe
`default_nettype wire
